// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Control FSM for a single, shared, iterative AES round datapath. It accepts
// one 128-bit block per handshake, steps the datapath through the initial
// AddRoundKey, NR-1 full rounds and the final round (no MixColumns), then
// presents the finished block with a valid/ready handshake. Decryption walks
// the key schedule backwards and selects the inverse datapath.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   key_ready   expanded key schedule is stable; gates acceptance only
//   in_valid    input block presented
//   in_decrypt  direction of presented block (1 = decrypt), sampled on accept
//   in_ready    block can be accepted this cycle (combinational)
//   st_load     datapath loads its state register at the end of this cycle
//   st_sel      0 = initial AddRoundKey, 1 = full round, 2 = final round
//   rk_idx      round-key index into the key schedule (0..NR)
//   dir_dec     direction of the block in flight
//   out_valid   state register holds a finished block
//   out_ready   consumer takes the block
//   busy        high in every state except IDLE
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_ready,
    input  logic             in_valid,
    input  logic             in_decrypt,
    output logic             in_ready,
    output logic             st_load,
    output logic [1:0]       st_sel,
    output logic [IDX_W-1:0] rk_idx,
    output logic             dir_dec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [1:0]       SEL_INIT  = 2'd0;
    localparam logic [1:0]       SEL_ROUND = 2'd1;
    localparam logic [1:0]       SEL_FINAL = 2'd2;
    localparam logic [IDX_W-1:0] NR_IDX    = IDX_W'(NR);
    localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(NR - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] r_q, r_d;
    logic             dir_q, dir_d;
    // Last driven rk_idx/st_sel, so they hold steady while the datapath idles.
    logic [IDX_W-1:0] rk_q, rk_d;
    logic [1:0]       sel_q, sel_d;
    logic             accept;

    assign dir_dec   = dir_q;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d  = state_q;
        r_d      = r_q;
        dir_d    = dir_q;
        st_load  = 1'b0;
        st_sel   = sel_q;
        rk_idx   = rk_q;
        in_ready = key_ready && ((state_q == S_IDLE) ||
                                 ((state_q == S_DONE) && out_ready));
        accept   = in_valid && in_ready;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_INIT;
                    dir_d   = in_decrypt;
                end
            end
            S_INIT: begin
                st_load = 1'b1;
                st_sel  = SEL_INIT;
                rk_idx  = dir_q ? NR_IDX : '0;
                r_d     = IDX_ONE;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                st_load = 1'b1;
                st_sel  = SEL_ROUND;
                rk_idx  = dir_q ? (NR_IDX - r_q) : r_q;
                r_d     = r_q + IDX_ONE;
                if (r_q == LAST_FULL) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                st_load = 1'b1;
                st_sel  = SEL_FINAL;
                rk_idx  = dir_q ? '0 : NR_IDX;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Accept in the same cycle the result leaves: no idle bubble.
                if (out_ready) begin
                    if (accept) begin
                        state_d = S_INIT;
                        dir_d   = in_decrypt;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rk_d  = rk_idx;
        sel_d = st_sel;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            dir_q   <= 1'b0;
            rk_q    <= '0;
            sel_q   <= SEL_INIT;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dir_q   <= dir_d;
            rk_q    <= rk_d;
            sel_q   <= sel_d;
        end
    end

endmodule
